uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmit line between NUM_REQ byte sources using round-robin arbitration.
//   Sequences each 8N1 frame itself from an internal baud clock-enable; it does not generate a clock.
//   Sits between requester logic and the board TX pin, beside the existing baud rate generator.
// PARAMETERS
//   CLOCK_RATE  100000000  system clock frequency, Hz
//   BAUD_RATE   115200     line rate, bit/s
//   NUM_REQ     4          number of requesters, 2..16
//   DATA_BITS   8          payload bits per frame, LSB first
// PORTS
//   clk    in   1                  system clock; all logic on posedge
//   rst    in   1                  asynchronous, active-high reset
//   req    in   NUM_REQ            level request per source; held until its grant pulse
//   data   in   NUM_REQ*DATA_BITS  byte of source i at [i*DATA_BITS +: DATA_BITS]; stable while req[i]=1
//   grant  out  NUM_REQ            one-hot, one-cycle pulse: byte of that source captured
//   owner  out  $clog2(NUM_REQ)    index of source currently transmitting (valid while busy)
//   busy   out  1                  1 from grant edge through the final stop-bit cycle
//   txd    out  1                  serial line; idles high
// BEHAVIOUR
//   - Constants: BIT_CYCLES = CLOCK_RATE/BAUD_RATE, integer-truncated. BIT_CYCLES >= 2 is required
//     (elaboration error otherwise). Counter width = $clog2(BIT_CYCLES).
//   - Reset (async assert, sync release): state=IDLE, txd=1, grant=0, busy=0, owner=0,
//     bit_cnt=0, tick_cnt=0, last_grant=NUM_REQ-1, so source 0 has first priority.
//   - FSM states: IDLE, START, DATA, STOP. All outputs are registered.
//   - IDLE: if any req bit is set at edge n, then at edge n+1:
//     - Winner = first set bit searching last_grant+1 upward, wrapping modulo NUM_REQ.
//     - grant[winner]=1 for exactly one cycle; data slice latched into shift reg.
//     - owner=winner, last_grant=winner, busy=1, txd=0, tick_cnt cleared, state=START.
//   - Bit timing: every bit (start, each data bit, stop) lasts exactly BIT_CYCLES clocks.
//     The tick counter restarts at grant; there is no free-running phase error.
//   - START -> DATA after BIT_CYCLES cycles; txd = shift[0].
//   - DATA: shift right each bit period. After DATA_BITS bits -> STOP with txd=1.
//   - STOP: after BIT_CYCLES cycles -> IDLE with busy=0.
//   - Frame length is (DATA_BITS+2)*BIT_CYCLES cycles. IDLE costs one further cycle,
//     so back-to-back frames have a 1-cycle extra high gap.
//   - Requests arriving while busy are not granted; they wait, and are evaluated in IDLE only.
//   - Simultaneous requests: only the winner is granted; losers keep req high and win in later
//     rounds. No source is starved; worst-case wait is NUM_REQ-1 frames.
//   - Dropped requests: if a requester drops req before grant, nothing is sent; no state change.
//   - req deasserted mid-frame has no effect: the byte is already captured.
//   - Requests during reset are ignored.
//   - rst mid-frame: txd returns high immediately (async); the frame is aborted and not retried.
//   - last_grant wraps from NUM_REQ-1 to 0.
// STRUCTURE
//   - Shared package uart_pkg:
//     - tx_state_t enum {IDLE, START, DATA, STOP}.
//     - function bit_cycles(clock_rate, baud_rate).
//     - localparam UART_IDLE_LEVEL = 1'b1.
//   - Sub-module rr_arbiter #(N): combinational one-hot winner from req and last_grant.
//     Reusable for later shared UART resources.
//   - Top holds FSM, tick counter, bit counter and shift register.
// TESTING  (CLOCK_RATE=1_000_000, BAUD_RATE=100_000 -> BIT_CYCLES=10; NUM_REQ=4)
//   1. Reset: rst pulse mid-sim -> txd=1, busy=0, grant=0 asynchronously; after release,
//      first grant goes to source 0 when all req=4'b1111.
//   2. Single frame: req=4'b0100, data[2]=8'hA5, held until grant -> grant=4'b0100 one cycle later.
//      txd = 0,1,0,1,0,0,1,0,1,1, each level 10 cycles; busy high exactly 100 cycles; owner=2.
//   3. Round robin: req=4'b1111 held, each source dropping after its grant.
//      -> grant order 0,1,2,3; grants 101 cycles apart.
//   4. Wrap and skip: last_grant=3, req=4'b1010 -> grant source 1, then source 3, then source 1.
//   5. Late request: req[3] raised at cycle 50 of a source-0 frame -> no grant until IDLE.
//      Then grant[3] 1 cycle after busy falls.
//   6. Abort: rst at cycle 35 of frame, req still high -> txd=1 at once.
//      After release, source 0 is regranted and a full 100-cycle frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int unsigned bit_cycles(input int unsigned clock_rate,
                                               input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after lastGrant, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] lastGrant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] winner,
    output logic                 valid
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            logic [IW-1:0] idx;
            idx = IW'((32'(lastGrant) + i) % N);
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared 8N1 UART transmitter: grants one requester, captures its byte and
// serialises start, data (LSB first) and stop bits, each BIT_CYCLES clocks long.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         busy,
    output logic                         txd
);

    localparam int unsigned BIT_CYCLES = bit_cycles(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned CW         = $clog2(BIT_CYCLES);
    localparam int unsigned OW         = $clog2(NUM_REQ);
    localparam int unsigned BW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (BIT_CYCLES < 2) begin : g_bitCyclesCheck
        $error("uart_tx_arbiter: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_numReqCheck
        $error("uart_tx_arbiter: NUM_REQ must be in 2..16");
    end

    tx_state_t            state;
    logic [CW-1:0]        tickCnt;
    logic [BW-1:0]        bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic [OW-1:0]        lastGrant;
    logic [NUM_REQ-1:0]   arbGrant;
    logic [OW-1:0]        arbWinner;
    logic                 arbValid;
    logic                 tickDone;
    logic [DATA_BITS-1:0] slot [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot[g] = data[g*DATA_BITS +: DATA_BITS];
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req),
        .lastGrant (lastGrant),
        .grant     (arbGrant),
        .winner    (arbWinner),
        .valid     (arbValid)
    );

    assign tickDone  = (tickCnt == TICK_LAST);
    assign shiftNext = shiftReg >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            txd       <= UART_IDLE_LEVEL;
            grant     <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            bitCnt    <= '0;
            tickCnt   <= '0;
            shiftReg  <= '0;
            lastGrant <= OW'(NUM_REQ - 1);
        end else begin
            grant <= '0;
            unique case (state)
                IDLE: begin
                    if (arbValid) begin
                        grant     <= arbGrant;
                        shiftReg  <= slot[arbWinner];
                        owner     <= arbWinner;
                        lastGrant <= arbWinner;
                        busy      <= 1'b1;
                        txd       <= ~UART_IDLE_LEVEL;
                        tickCnt   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tickDone) begin
                        tickCnt <= '0;
                        bitCnt  <= '0;
                        txd     <= shiftReg[0];
                        state   <= DATA;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tickDone) begin
                        tickCnt <= '0;
                        if (bitCnt == BIT_LAST) begin
                            txd   <= UART_IDLE_LEVEL;
                            state <= STOP;
                        end else begin
                            // txd takes the next bit directly so it lines up with the shift
                            shiftReg <= shiftNext;
                            txd      <= shiftNext[0];
                            bitCnt   <= bitCnt + 1'b1;
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tickDone) begin
                        tickCnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a frame-level model predicts grants and line levels,
// a negedge monitor compares every cycle of every frame and the idle line between frames.
module tb_uart_tx_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned BITC = 10;
    localparam int unsigned FRAME = 10 * BITC;

    typedef struct {
        int unsigned edgeIdx;
        int unsigned src;
        logic [7:0]  b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*8-1:0] data;
    logic [NR-1:0] grant;
    logic [1:0]    owner;
    logic          busy;
    logic          txd;

    logic [NR-1:0] pend;
    logic [7:0]    bytes [NR];
    exp_t          q [$];
    int unsigned   edgeCnt = 0;
    int unsigned   freeAt;
    int unsigned   lastG;
    int            monPos = -1;
    logic [7:0]    curByte;
    int unsigned   checks = 0;
    int unsigned   failures = 0;

    uart_tx_arbiter #(
        .CLOCK_RATE (1000000),
        .BAUD_RATE  (100000),
        .NUM_REQ    (NR),
        .DATA_BITS  (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .txd   (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt = edgeCnt + 1;

    assign req  = pend;
    assign data = {bytes[3], bytes[2], bytes[1], bytes[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    // 8N1 frame: start low, data LSB first, stop high, each bit BITC cycles
    function automatic logic expLevel(input int k, input logic [7:0] b);
        int bi;
        bi = k / BITC;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    // Decide what the arbiter does at the coming edge given the request lines as now driven.
    task automatic modelEval();
        int unsigned w;
        bit found;
        found = 0;
        w = 0;
        if (!rst && edgeCnt + 1 >= freeAt && pend != '0) begin
            for (int unsigned j = 1; j <= NR; j++) begin
                int unsigned idx;
                idx = (lastG + j) % NR;
                if (!found && pend[idx]) begin
                    found = 1;
                    w = idx;
                end
            end
            q.push_back('{edgeIdx: edgeCnt + 1, src: w, b: bytes[w]});
            freeAt = edgeCnt + 1 + FRAME + 1;
            lastG  = w;
        end
    endtask

    task automatic raise(input int unsigned i, input logic [7:0] b);
        if (!pend[i]) begin
            bytes[i] = b;
            pend[i]  = 1'b1;
        end
        modelEval();
    endtask

    task automatic step(input bit allowRand);
        @(negedge clk);
        for (int unsigned i = 0; i < NR; i++)
            if (grant[i]) pend[i] = 1'b0;
        if (allowRand) begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 59) == 0) begin
                    bytes[i] = 8'($urandom);
                    pend[i]  = 1'b1;
                end else if (pend[i] && $urandom_range(0, 399) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        modelEval();
    endtask

    task automatic steps(input int unsigned n, input bit allowRand);
        for (int unsigned k = 0; k < n; k++) step(allowRand);
    endtask

    task automatic doReset(input int unsigned cycles);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_txd", txd, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_grant", grant, 0);
        q.delete();
        lastG  = NR - 1;
        freeAt = 0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        modelEval();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            monPos = -1;
        end else begin
            if (grant != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", grant, 0);
                end else begin
                    exp_t e;
                    logic [NR-1:0] oh;
                    e = q.pop_front();
                    oh = '0;
                    oh[e.src] = 1'b1;
                    chk("grant_onehot", grant, oh);
                    chk("owner", owner, e.src);
                    chk("grant_edge", edgeCnt, e.edgeIdx);
                    curByte = e.b;
                    monPos  = 0;
                end
            end else if (q.size() > 0 && q[0].edgeIdx <= edgeCnt) begin
                chk("missed_grant", grant, 32'(1) << q[0].src);
                void'(q.pop_front());
            end
            if (monPos >= 0) begin
                chk("frame_txd", txd, expLevel(monPos, curByte));
                chk("frame_busy", busy, 1);
                monPos++;
                if (monPos == int'(FRAME)) monPos = -1;
            end else begin
                chk("idle_line", {busy, txd}, 2'b01);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pend   = '0;
        for (int unsigned i = 0; i < NR; i++) bytes[i] = '0;
        lastG  = NR - 1;
        freeAt = 0;
        repeat (3) @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant, 0);
        chk("reset_owner", owner, 0);
        rst = 1'b0;
        modelEval();

        // all four requesting: 0 first after reset, then 1, 2, 3 one frame apart
        for (int unsigned i = 0; i < NR; i++) raise(i, 8'($urandom));
        steps(420, 0);

        raise(2, 8'hA5);
        steps(110, 0);

        // wrap and skip with only sources 1 and 3 requesting
        raise(3, 8'h3C);
        steps(105, 0);
        raise(1, 8'h81);
        raise(3, 8'h7E);
        steps(105, 0);
        raise(1, 8'h00);
        steps(220, 0);

        // late request during a source-0 frame
        raise(0, 8'hFF);
        steps(50, 0);
        raise(3, 8'h5A);
        steps(160, 0);

        // abort mid-frame with source 0 requesting again
        raise(0, 8'hC3);
        steps(35, 0);
        raise(0, 8'h96);
        doReset(2);
        steps(110, 0);

        for (int unsigned k = 0; k < 3000; k++) begin
            if (k == 1500) doReset($urandom_range(1, 4));
            step(1);
        end
        steps(450, 0);

        chk("queue_drained", q.size(), 0);
        chk("pending_drained", pend, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
